// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
//   arb_state_t : arbiter FSM states
//   port_sel_t  : which requester currently owns the memory port
package mips_mem_pkg;

   localparam int unsigned DEF_ADDR_W    = 32;
   localparam int unsigned DEF_DATA_W    = 32;
   localparam int unsigned DEF_MAX_WAIT  = 4;
   localparam int unsigned DEF_BURST_LEN = 2;

   typedef enum logic [1:0] {
      NORM    = 2'd0,
      FORCE_D = 2'd1,
      COOL    = 2'd2
   } arb_state_t;

   typedef enum logic {
      SEL_P = 1'b0,
      SEL_D = 1'b1
   } port_sel_t;

endpackage

// File: rtl/dmem_port_mux.sv
// Owner mux for the single memory port (purely combinational).
//   sel          : current owner (SEL_P / SEL_D)
//   p_* / d_*    : request, write enable, address, write data of each port
//   we/addr/wd   : selected memory command; we is qualified by the owner's request
module dmem_port_mux
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  port_sel_t          sel,
   input  logic               p_req,
   input  logic               p_we,
   input  logic [ADDR_W-1:0]  p_addr,
   input  logic [DATA_W-1:0]  p_wd,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [DATA_W-1:0]  d_wd,
   output logic               we,
   output logic [ADDR_W-1:0]  addr,
   output logic [DATA_W-1:0]  wd
);

   // P is the default owner, so an idle port presents p_addr with no write
   always_comb begin
      we   = p_we & p_req;
      addr = p_addr;
      wd   = p_wd;
      if (sel == SEL_D) begin
         we   = d_we & d_req;
         addr = d_addr;
         wd   = d_wd;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the data memory between the MEM stage (P, priority) and a
// debug/loader port (D) that gets a forced burst after MAX_WAIT refusals.
//   CLK, Reset             : clock, async active-high reset
//   p_req/p_we/p_addr/p_wd : MEM-stage access; p_rd read data, p_stall hold request
//   d_req/d_we/d_addr/d_wd : debug access; d_gnt grant, d_rd/d_rvalid read return
//   mem_we/mem_addr/mem_wd : memory command; mem_rd combinational read data
module dmem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT,
   parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               p_req,
   input  logic               p_we,
   input  logic [ADDR_W-1:0]  p_addr,
   input  logic [DATA_W-1:0]  p_wd,
   output logic [DATA_W-1:0]  p_rd,
   output logic               p_stall,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [DATA_W-1:0]  d_wd,
   output logic               d_gnt,
   output logic [DATA_W-1:0]  d_rd,
   output logic               d_rvalid,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wd,
   input  logic [DATA_W-1:0]  mem_rd
);

   localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
   localparam int unsigned BURST_W = $clog2(BURST_LEN + 1);

   arb_state_t           state, state_nxt;
   logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
   logic [BURST_W-1:0]   burst_cnt, burst_nxt;
   port_sel_t            sel;
   logic                 mux_we;

   // State register, counters and the registered D read return
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state     <= NORM;
         wait_cnt  <= '0;
         burst_cnt <= '0;
         d_rd      <= '0;
         d_rvalid  <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_nxt;
         burst_cnt <= burst_nxt;
         d_rvalid  <= d_gnt & ~d_we;
         if (d_gnt && !d_we) begin
            d_rd <= mem_rd;
         end
      end
   end

   // Next state and counter updates
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      burst_nxt = burst_cnt;
      unique case (state)
         NORM: begin
            if (!d_req || sel == SEL_D) begin
               wait_nxt = '0;
            end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
               // this refusal is the MAX_WAIT-th in a row
               state_nxt = FORCE_D;
               wait_nxt  = '0;
            end else begin
               wait_nxt = WAIT_W'(wait_cnt + 1'b1);
            end
         end
         FORCE_D: begin
            wait_nxt = '0;
            if (!d_req || burst_cnt == BURST_W'(BURST_LEN - 1)) begin
               state_nxt = COOL;
               burst_nxt = '0;
            end else begin
               burst_nxt = BURST_W'(burst_cnt + 1'b1);
            end
         end
         COOL: begin
            state_nxt = NORM;
            if (!d_req) begin
               wait_nxt = '0;
            end
         end
         default: begin
            state_nxt = NORM;
            wait_nxt  = '0;
            burst_nxt = '0;
         end
      endcase
   end

   // Owner selection and grant/stall outputs; all gated off while in reset
   always_comb begin
      sel = SEL_P;
      unique case (state)
         NORM:    if (d_req && !p_req) sel = SEL_D;
         FORCE_D: if (d_req)           sel = SEL_D;
         default: sel = SEL_P;
      endcase
      d_gnt   = (sel == SEL_D) & ~Reset;
      p_stall = p_req & (sel == SEL_D) & ~Reset;
      mem_we  = mux_we & ~Reset;
   end

   assign p_rd = mem_rd;

   dmem_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mux (
      .sel    (sel),
      .p_req  (p_req),
      .p_we   (p_we),
      .p_addr (p_addr),
      .p_wd   (p_wd),
      .d_req  (d_req),
      .d_we   (d_we),
      .d_addr (d_addr),
      .d_wd   (d_wd),
      .we     (mux_we),
      .addr   (mem_addr),
      .wd     (mem_wd)
   );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// randomized traffic, checked against a rule-level model of the arbiter.
module tb_dmem_port_arbiter;

   localparam int unsigned MW = 4;
   localparam int unsigned BL = 2;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        p_req, p_we, p_stall;
   logic [31:0] p_addr, p_wd, p_rd;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wd, d_rd;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wd, mem_rd;
   logic        mem_clr;

   always #5 CLK = ~CLK;

   dmem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW), .BURST_LEN(BL)
   ) dut (
      .CLK(CLK), .Reset(Reset),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wd(p_wd),
      .p_rd(p_rd), .p_stall(p_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
      .d_gnt(d_gnt), .d_rd(d_rd), .d_rvalid(d_rvalid),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   // Data memory: combinational read, synchronous write (low 8 address bits)
   logic [31:0] mem [256];
   assign mem_rd = mem[mem_addr[7:0]];
   always @(posedge CLK) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wd;
      end
   end

   int passed = 0;
   int total  = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference model: refusals in a row, grants left in a forced burst,
   // a one-cycle cool-down flag, and a shadow copy of memory.
   int          refused, burst_left;
   bit          cool;
   logic [31:0] ref_mem [256];
   logic [31:0] model_drd;
   logic        obs_gnt;
   logic [31:0] obs_prd;

   task automatic model_reset();
      refused    = 0;
      burst_left = 0;
      cool       = 0;
      model_drd  = '0;
   endtask

   // One clock cycle: drive, check combinational outputs, advance model, check registered outputs
   task automatic cyc(input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pwd,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd);
      logic eg, ewe, erv;
      logic [31:0] ewa, ewd;
      p_req = pr; p_we = pw; p_addr = pa; p_wd = pwd;
      d_req = dr; d_we = dw; d_addr = da; d_wd = dwd;
      #4;
      if (cool)                eg = 1'b0;
      else if (burst_left > 0) eg = dr;
      else                     eg = dr & ~pr;
      ewe = eg ? dw : (pr & pw);
      ewa = eg ? da : pa;
      ewd = eg ? dwd : pwd;
      erv = eg & ~dw;
      chk1("d_gnt", d_gnt, eg);
      chk1("p_stall", p_stall, pr & eg);
      chk1("mem_we", mem_we, ewe);
      chk32("mem_addr", mem_addr, ewa);
      if (ewe) chk32("mem_wd", mem_wd, ewd);
      if (pr && !eg) chk32("p_rd", p_rd, ref_mem[pa[7:0]]);
      obs_gnt = d_gnt;
      obs_prd = p_rd;
      if (erv) model_drd = ref_mem[da[7:0]];
      if (ewe) ref_mem[ewa[7:0]] = ewd;
      if (cool) begin
         cool = 0;
      end else if (burst_left > 0) begin
         if (!dr) begin
            burst_left = 0;
            cool = 1;
         end else begin
            burst_left--;
            if (burst_left == 0) cool = 1;
         end
      end else if (!dr || eg) begin
         refused = 0;
      end else begin
         refused++;
         if (refused == MW) begin
            refused    = 0;
            burst_left = BL;
         end
      end
      @(posedge CLK);
      #1;
      chk1("d_rvalid", d_rvalid, erv);
      chk32("d_rd", d_rd, model_drd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
   endtask

   initial begin
      bit          dpend;
      logic        rdw;
      logic [31:0] rda, rdwd;

      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      model_reset();
      mem_clr = 1'b1;
      Reset   = 1'b1;
      // requests present during reset must be ignored
      p_req = 1; p_we = 1; p_addr = 32'h4; p_wd = 32'h1;
      d_req = 1; d_we = 1; d_addr = 32'h8; d_wd = 32'h2;
      #22;
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_d_gnt", d_gnt, 1'b0);
      chk1("rst_p_stall", p_stall, 1'b0);
      chk1("rst_d_rvalid", d_rvalid, 1'b0);
      chk32("rst_d_rd", d_rd, 32'h0);
      p_req = 0; p_we = 0; d_req = 0; d_we = 0;
      mem_clr = 1'b0;
      #1 Reset = 1'b0;
      @(posedge CLK);
      #1;

      // P alone: write then read back
      cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
      cyc(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
      chk32("p_readback", obs_prd, 32'hDEADBEEF);

      // D alone: read of the same word
      cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
      chk1("d_only_gnt", obs_gnt, 1'b1);
      chk32("d_only_rd", d_rd, 32'hDEADBEEF);

      // Sustained contention: period MW refusals + BL forced grants + 1 cool cycle
      for (int c = 0; c < 14; c++) begin
         cyc(1, 0, 32'h20, 32'h0, 1, 0, 32'h10, 32'h0);
         chk1("contend_gnt", obs_gnt, (c % 7 == 4) || (c % 7 == 5));
      end
      idle(2);

      // Burst cut short by d_req dropping, then cool-down refusal with P idle
      for (int c = 0; c < 4; c++) cyc(1, 0, 32'h30, 32'h0, 1, 1, 32'h40, 32'h1234);
      cyc(1, 0, 32'h30, 32'h0, 1, 1, 32'h40, 32'h1234);
      chk1("cut_first_gnt", obs_gnt, 1'b1);
      cyc(1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0);
      chk1("cut_drop_gnt", obs_gnt, 1'b0);
      cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
      chk1("cool_refuse", obs_gnt, 1'b0);
      cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
      chk1("after_cool_gnt", obs_gnt, 1'b1);
      chk32("after_cool_rd", d_rd, 32'h1234);
      // wait count restarted: MW full refusals before the next forced grant
      for (int c = 0; c < 5; c++) begin
         cyc(1, 0, 32'h50, 32'h0, 1, 0, 32'h40, 32'h0);
         chk1("restart_gnt", obs_gnt, c == 4);
      end
      idle(3);

      // Asynchronous reset in the middle of a forced burst
      for (int c = 0; c < 4; c++) cyc(1, 1, 32'h60, 32'h77, 1, 0, 32'h10, 32'h0);
      p_req = 1; p_we = 1; d_req = 1; d_we = 0; d_addr = 32'h10;
      #2;
      chk1("pre_rst_gnt", d_gnt, 1'b1);
      chk1("pre_rst_stall", p_stall, 1'b1);
      Reset = 1'b1;
      #1;
      chk1("async_p_stall", p_stall, 1'b0);
      chk1("async_d_gnt", d_gnt, 1'b0);
      chk1("async_mem_we", mem_we, 1'b0);
      model_reset();
      #4;
      p_req = 0; p_we = 0; d_req = 0;
      Reset = 1'b0;
      @(posedge CLK);
      #1;
      chk1("post_rst_rvalid", d_rvalid, 1'b0);
      chk32("post_rst_d_rd", d_rd, 32'h0);
      // NORM again: contention is refused
      cyc(1, 0, 32'h60, 32'h0, 1, 0, 32'h10, 32'h0);
      chk1("post_rst_refuse", obs_gnt, 1'b0);

      // Randomized traffic; a D request holds its command until granted
      dpend = 0; rdw = 0; rda = '0; rdwd = '0;
      for (int i = 0; i < 400; i++) begin
         if (!dpend && ($urandom % 3 == 0)) begin
            dpend = 1;
            rdw   = 1'($urandom % 2);
            rda   = $urandom;
            rdwd  = $urandom;
         end
         cyc(1'($urandom % 4 != 0), 1'($urandom % 2), $urandom, $urandom,
             dpend, rdw, rda, rdwd);
         if (obs_gnt) dpend = 0;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (port P) and a debug/program-loader port (port D).
- P has priority. D is guaranteed service after a bounded wait by forcing a short burst and stalling the pipeline.
- Sits between the MEM-stage control/datapath and the data memory instance; also drives the MEM-stage stall.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive cycles D may be refused before a forced grant (>=1).
- BURST_LEN, 2, maximum consecutive D grants in one forced burst (>=1).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- p_req  in  1  MEM-stage instruction accesses memory this cycle.
- p_we  in  1  P write enable (MemWriteM).
- p_addr  in  ADDR_W  P address (ALUOutM).
- p_wd  in  DATA_W  P write data (WriteDataM).
- p_rd  out  DATA_W  P read data (ReadDataM), combinational from mem_rd.
- p_stall  out  1  P refused this cycle; pipeline must hold the MEM stage.
- d_req  in  1  D request; held until d_gnt.
- d_we  in  1  D write enable.
- d_addr  in  ADDR_W  D address.
- d_wd  in  DATA_W  D write data.
- d_gnt  out  1  D access performed this cycle.
- d_rd  out  DATA_W  registered D read data.
- d_rvalid  out  1  one-cycle pulse, d_rd valid (cycle after a granted D read).
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory read data (combinational read).

Behaviour:
- Memory is a combinational-read / synchronous-write array, so one access per cycle. Owner is chosen combinationally from the current state and requests.
- FSM states: NORM, FORCE_D, COOL.
  - NORM: grant D iff d_req && !p_req; otherwise P owns. If d_req && p_req, wait_cnt increments. When wait_cnt reaches MAX_WAIT with d_req still high, next state is FORCE_D and wait_cnt clears.
  - FORCE_D: D owns whenever d_req is high. p_stall = p_req. burst_cnt counts grants. Exit to COOL when burst_cnt == BURST_LEN-1 on a grant, or when d_req drops.
  - COOL: one cycle, P owns. D is refused even if P is idle. Returns to NORM. Guarantees pipeline progress.
- wait_cnt clears on any D grant or when d_req is low.
- Mux: mem_addr/mem_wd follow the owner. With no request granted, mem_addr = p_addr and mem_we = 0. mem_we = owner_we & owner_req.
- p_rd = mem_rd every cycle; valid only when P owns and !p_stall.
- p_stall = p_req && D owns.
- D read: when d_gnt && !d_we, d_rd <= mem_rd, and d_rvalid = 1 next cycle. d_rd holds its value otherwise.
- D write completes in the d_gnt cycle; no d_rvalid.
- Simultaneous p_req/d_req in NORM with wait_cnt < MAX_WAIT: P wins, d_gnt = 0.
- d_req dropping mid-burst ends the burst (goes to COOL). A D request must not change d_addr/d_we/d_wd while waiting.
- Reset (async, any state): state = NORM, wait_cnt = 0, burst_cnt = 0, d_rd = 0, d_rvalid = 0. While Reset is high, mem_we = 0, d_gnt = 0, p_stall = 0.
- Counters are sized by $clog2(MAX_WAIT+1) and $clog2(BURST_LEN+1); no wrap is possible because they clear at their limits.

Decomposition:
- Shared package mips_mem_pkg: FSM state enum (NORM, FORCE_D, COOL), default widths, and port-select encodings (SEL_P, SEL_D).
- One natural sub-module, dmem_port_mux: purely combinational owner mux for addr/wd/we.
- FSM and counters stay in the top module.

Test Plan:
- Only P: p_req=1, p_we=1, p_addr=0x10, p_wd=0xDEADBEEF -> mem_we=1, mem_addr=0x10, p_stall=0, d_gnt=0; next P read of 0x10 gives p_rd=0xDEADBEEF.
- Only D read: d_req=1, d_we=0, d_addr=0x10 -> d_gnt=1 that cycle; next cycle d_rvalid=1, d_rd=0xDEADBEEF.
- Contention: p_req and d_req held high, MAX_WAIT=4, BURST_LEN=2 -> cycles 0-3 P owns, d_gnt=0; cycles 4-5 d_gnt=1 with p_stall=1; cycle 6 COOL, P owns with p_stall=0; cycles 7-10 P owns again, and the pattern repeats.
- Burst cut: enter FORCE_D, drop d_req after 1 grant -> COOL next cycle, then NORM, wait_cnt=0.
- Async reset in FORCE_D mid-burst -> immediately p_stall=0, d_gnt=0, mem_we=0; after release, state NORM, d_rvalid=0.
- COOL refusal: P idle, d_req high in COOL -> d_gnt=0 that cycle, d_gnt=1 the following cycle.
